// File: rtl/vx_onehot_stream_arb.sv
// rtl/vx_onehot_stream_arb.sv - round-robin one-hot valid/ready stream arbiter
// Optional output pipeline register enabled by defining VX_ONEHOT_ARB_OUTREG_EN.
module vx_onehot_stream_arb #(
  parameter int NUM_REQS     = 4,
  parameter int DATAW        = 32,
  parameter int LOG_NUM_REQS = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       valid_in,
  input  logic [NUM_REQS*DATAW-1:0] data_in,
  output logic [NUM_REQS-1:0]       ready_in,
  output logic                      valid_out,
  output logic [DATAW-1:0]          data_out,
  output logic [NUM_REQS-1:0]       sel_out,
  output logic [LOG_NUM_REQS-1:0]   idx_out,
  input  logic                      ready_out
);

  typedef enum logic {IDLE, LOCKED} state_e;

  // First requester at or after ptr, searching circularly.
  function automatic logic [NUM_REQS-1:0] rr_pick(input logic [NUM_REQS-1:0] req,
                                                  input logic [LOG_NUM_REQS-1:0] ptr);
    logic [NUM_REQS-1:0] g;
    logic                found;
    int                  idx;
    g     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQS; i++) begin
      idx = (int'(ptr) + i) % NUM_REQS;
      if (!found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic logic [LOG_NUM_REQS-1:0] encode(input logic [NUM_REQS-1:0] s);
    logic [LOG_NUM_REQS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (s[i]) r = r | LOG_NUM_REQS'(i);
    end
    return r;
  endfunction

  function automatic logic [LOG_NUM_REQS-1:0] next_ptr(input logic [NUM_REQS-1:0] s);
    logic [LOG_NUM_REQS-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      if (s[i]) r = (i == NUM_REQS - 1) ? '0 : LOG_NUM_REQS'(i + 1);
    end
    return r;
  endfunction

  function automatic logic [DATAW-1:0] onehot_mux(input logic [NUM_REQS-1:0] s,
                                                  input logic [NUM_REQS*DATAW-1:0] d);
    logic [DATAW-1:0] r;
    r = '0;
    for (int i = 0; i < NUM_REQS; i++) begin
      r = r | (d[i*DATAW +: DATAW] & {DATAW{s[i]}});
    end
    return r;
  endfunction

  if (NUM_REQS == 1) begin : g_passthru

    assign valid_out = valid_in[0];
    assign ready_in  = ready_out;
    assign data_out  = data_in[DATAW-1:0];
    assign sel_out   = '1;
    assign idx_out   = '0;

  end else begin : g_arb

    logic [LOG_NUM_REQS-1:0] rr_ptr_q, rr_ptr_d;
    logic [NUM_REQS-1:0]     grant;

`ifdef VX_ONEHOT_ARB_OUTREG_EN
    logic                    valid_q, valid_d;
    logic [DATAW-1:0]        data_q, data_d;
    logic [NUM_REQS-1:0]     sel_q, sel_d;
    logic [LOG_NUM_REQS-1:0] idx_q, idx_d;
    logic                    take;

    always_comb begin
      rr_ptr_d = rr_ptr_q;
      valid_d  = valid_q;
      data_d   = data_q;
      sel_d    = sel_q;
      idx_d    = idx_q;
      grant    = rr_pick(valid_in, rr_ptr_q);
      take     = reset & (|valid_in) & (~valid_q | ready_out);
      ready_in = take ? grant : '0;
      if (take) begin
        valid_d  = 1'b1;
        data_d   = onehot_mux(grant, data_in);
        sel_d    = grant;
        idx_d    = encode(grant);
        rr_ptr_d = next_ptr(grant);
      end else if (ready_out) begin
        valid_d = 1'b0;
        sel_d   = '0;
        idx_d   = '0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rr_ptr_q <= '0;
        valid_q  <= 1'b0;
        data_q   <= '0;
        sel_q    <= '0;
        idx_q    <= '0;
      end else begin
        rr_ptr_q <= rr_ptr_d;
        valid_q  <= valid_d;
        data_q   <= data_d;
        sel_q    <= sel_d;
        idx_q    <= idx_d;
      end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign sel_out   = sel_q;
    assign idx_out   = idx_q;
`else
    state_e              state_q, state_d;
    logic [NUM_REQS-1:0] lock_sel_q, lock_sel_d;

    // While stalled the latched grant wins over any newly arriving request.
    always_comb begin
      state_d    = state_q;
      lock_sel_d = lock_sel_q;
      rr_ptr_d   = rr_ptr_q;
      grant      = (state_q == LOCKED) ? lock_sel_q : rr_pick(valid_in, rr_ptr_q);
      valid_out  = reset & (|valid_in);
      sel_out    = valid_out ? grant : '0;
      idx_out    = encode(sel_out);
      data_out   = onehot_mux(sel_out, data_in);
      ready_in   = sel_out & {NUM_REQS{ready_out}};
      if (valid_out && ready_out) begin
        rr_ptr_d = next_ptr(sel_out);
        state_d  = IDLE;
      end else if (valid_out) begin
        state_d    = LOCKED;
        lock_sel_d = sel_out;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        state_q    <= IDLE;
        lock_sel_q <= '0;
        rr_ptr_q   <= '0;
      end else begin
        state_q    <= state_d;
        lock_sel_q <= lock_sel_d;
        rr_ptr_q   <= rr_ptr_d;
      end
    end
`endif

  end

endmodule

// File: tb/tb_vx_onehot_stream_arb.sv
// tb/tb_vx_onehot_stream_arb.sv - randomized self-checking bench for vx_onehot_stream_arb
module tb_vx_onehot_stream_arb;

  localparam int N = 4;
  localparam int W = 32;
`ifdef VX_ONEHOT_ARB_OUTREG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n;
  logic [N-1:0]   vin, rin, sout, hs;
  logic [N*W-1:0] din;
  logic           rdy, vout;
  logic [W-1:0]   dout;
  logic [1:0]     iout;

  logic [2:0]     vin3, rin3, sout3;
  logic [3*W-1:0] din3;
  logic           rdy3, vout3;
  logic [W-1:0]   dout3;
  logic [1:0]     iout3;

  logic           vin1, rin1, rdy1, vout1, sout1, iout1;
  logic [W-1:0]   din1, dout1;

  int errors = 0;
  int checks = 0;

  vx_onehot_stream_arb #(.NUM_REQS(N), .DATAW(W)) dut (
    .clk(clk), .reset(rst_n), .valid_in(vin), .data_in(din), .ready_in(rin),
    .valid_out(vout), .data_out(dout), .sel_out(sout), .idx_out(iout), .ready_out(rdy));

  vx_onehot_stream_arb #(.NUM_REQS(3), .DATAW(W)) dut3 (
    .clk(clk), .reset(rst_n), .valid_in(vin3), .data_in(din3), .ready_in(rin3),
    .valid_out(vout3), .data_out(dout3), .sel_out(sout3), .idx_out(iout3), .ready_out(rdy3));

  vx_onehot_stream_arb #(.NUM_REQS(1), .DATAW(W)) dut1 (
    .clk(clk), .reset(rst_n), .valid_in(vin1), .data_in(din1), .ready_in(rin1),
    .valid_out(vout1), .data_out(dout1), .sel_out(sout1), .idx_out(iout1), .ready_out(rdy1));

  // Reference model: priority index, held (stalled) winner, and output register contents.
  int         m_ptr  = 0;
  int         m_held = -1;
  logic       m_v    = 1'b0;
  logic [3:0] m_sel  = '0;
  logic [1:0] m_idx  = '0;
  logic [W-1:0] m_data = '0;

  function automatic int first_from(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++) begin
      if (v[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  // Packed as {valid, sel[3:0], idx[1:0], ready_in[3:0], data masked by valid}.
  function automatic logic [42:0] expect_out();
    int g;
    logic [3:0] sel;
    if (!rst_n) return '0;
`ifdef VX_ONEHOT_ARB_OUTREG_EN
    g   = first_from(vin, m_ptr);
    sel = (g >= 0 && (!m_v || rdy)) ? 4'(1 << g) : 4'b0;
    return {m_v, m_sel, m_idx, sel, m_v ? m_data : 32'h0};
`else
    g = (m_held >= 0) ? m_held : first_from(vin, m_ptr);
    if (g < 0) return '0;
    sel = 4'(1 << g);
    return {1'b1, sel, 2'(g), rdy ? sel : 4'b0, din[g*W +: W]};
`endif
  endfunction

  function automatic logic [42:0] observe();
    return {vout, sout, iout, rin, vout ? dout : 32'h0};
  endfunction

  task automatic model_edge();
    int g;
    if (!rst_n) begin
      m_ptr = 0; m_held = -1; m_v = 1'b0; m_sel = '0; m_idx = '0; m_data = '0;
      return;
    end
`ifdef VX_ONEHOT_ARB_OUTREG_EN
    g = first_from(vin, m_ptr);
    if (g >= 0 && (!m_v || rdy)) begin
      m_v = 1'b1; m_sel = 4'(1 << g); m_idx = 2'(g); m_data = din[g*W +: W];
      m_ptr = (g + 1) % N;
    end else if (rdy) begin
      m_v = 1'b0; m_sel = '0; m_idx = '0;
    end
`else
    g = (m_held >= 0) ? m_held : first_from(vin, m_ptr);
    if (g >= 0 && rdy) begin
      m_ptr  = (g + 1) % N;
      m_held = -1;
    end else if (g >= 0) begin
      m_held = g;
    end
`endif
  endtask

  task automatic tick();
    logic [42:0] e;
    e  = expect_out();
    hs = e[35:32];
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

`ifndef VX_ONEHOT_ARB_OUTREG_EN
  always @(negedge clk) begin
    #2;
    if (rst_n && m_held >= 0)
      assert (vin[m_held]) else $error("FAIL protocol: stalled input %0d dropped valid", m_held);
  end
`endif

  task automatic test_reset();
    rst_n = 1'b0; vin = 4'b1111; rdy = 1'b1;
    for (int i = 0; i < N; i++) din[i*W +: W] = $urandom();
    #1;
    checks++;
    if (vout !== 1'b0 || rin !== 4'b0)
      begin errors++; $display("FAIL reset_hold: valid_out=%b ready_in=%b exp 0/0000", vout, rin); end
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if (rin !== 4'b0001)
      begin errors++; $display("FAIL reset_first_grant: ready_in=%b exp 0001", rin); end
`ifndef VX_ONEHOT_ARB_OUTREG_EN
    checks++;
    if (sout !== 4'b0001 || iout !== 2'd0)
      begin errors++; $display("FAIL reset_first_sel: sel=%b idx=%0d exp 0001/0", sout, iout); end
`endif
    checks++;
    if (observe() !== expect_out())
      begin errors++; $display("FAIL reset_model: got %h exp %h", observe(), expect_out()); end
    tick();
  endtask

  task automatic test_rotation();
    rst_n = 1'b0; vin = 4'b0; tick();
    rst_n = 1'b1; vin = 4'b1111; rdy = 1'b1;
    for (int i = 0; i < N; i++) din[i*W +: W] = $urandom();
    for (int c = 0; c < 8; c++) begin
      #1;
      checks++;
      if (rin !== 4'(1 << (c % N)))
        begin errors++; $display("FAIL rotation_grant c%0d: ready_in=%b exp %b", c, rin, 4'(1 << (c % N))); end
      if (c >= LAT) begin
        checks++;
        if (iout !== 2'((c - LAT) % N) || dout !== din[((c - LAT) % N)*W +: W])
          begin errors++; $display("FAIL rotation_idx c%0d: idx=%0d data=%h exp %0d", c, iout, dout, (c - LAT) % N); end
      end
      checks++;
      if (observe() !== expect_out())
        begin errors++; $display("FAIL rotation_model c%0d: got %h exp %h", c, observe(), expect_out()); end
      tick();
    end
  endtask

  task automatic test_stall_lock();
    rst_n = 1'b0; vin = 4'b0; rdy = 1'b1; tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) din[i*W +: W] = $urandom();
    for (int c = 0; c < 3; c++) begin
      vin = (c < 2) ? 4'b0011 : 4'b0000;
      #1;
      checks++;
      if (observe() !== expect_out())
        begin errors++; $display("FAIL stall_setup_model c%0d: got %h exp %h", c, observe(), expect_out()); end
      tick();
    end
    rdy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vin = (c == 0) ? 4'b0100 : 4'b0101;
      #1;
      checks++;
      if (observe() !== expect_out())
        begin errors++; $display("FAIL stall_model c%0d: got %h exp %h", c, observe(), expect_out()); end
      if (c >= LAT) begin
        checks++;
        if (sout !== 4'b0100 || dout !== din[2*W +: W])
          begin errors++; $display("FAIL stall_hold c%0d: sel=%b data=%h exp 0100/%h", c, sout, dout, din[2*W +: W]); end
      end
      tick();
    end
    rdy = 1'b1; vin = 4'b1101;
    #1;
    checks++;
    if (observe() !== expect_out())
      begin errors++; $display("FAIL stall_release_model: got %h exp %h", observe(), expect_out()); end
    tick();
    vin = 4'b1001;
    #1;
    checks++;
    if (sout !== 4'b1000)
      begin errors++; $display("FAIL stall_next_grant: sel=%b exp 1000", sout); end
    tick();
  endtask

  task automatic test_reset_stall();
    vin = 4'b0010; rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++;
      if (observe() !== expect_out())
        begin errors++; $display("FAIL rststall_model c%0d: got %h exp %h", c, observe(), expect_out()); end
      tick();
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (vout !== 1'b0 || sout !== 4'b0 || iout !== 2'd0 || rin !== 4'b0)
      begin errors++; $display("FAIL rststall_outputs: v=%b sel=%b idx=%0d rdy=%b exp all 0", vout, sout, iout, rin); end
    tick();
    rst_n = 1'b1; vin = 4'b1111; rdy = 1'b1;
    #1;
    checks++;
    if (rin !== 4'b0001)
      begin errors++; $display("FAIL rststall_first_grant: ready_in=%b exp 0001", rin); end
    tick();
  endtask

  task automatic test_wrap3();
    logic [2:0] pat  [5] = '{3'b100, 3'b010, 3'b111, 3'b111, 3'b011};
    int         gidx [5] = '{2, 1, 2, 0, 1};
    vin = 4'b0; rdy3 = 1'b1;
    for (int i = 0; i < 3; i++) din3[i*W +: W] = $urandom();
    for (int c = 0; c < 5; c++) begin
      vin3 = pat[c];
      #1;
      checks++;
      if (rin3 !== 3'(1 << gidx[c]))
        begin errors++; $display("FAIL wrap3_grant c%0d: ready_in=%b exp %b", c, rin3, 3'(1 << gidx[c])); end
      if (c >= LAT) begin
        checks++;
        if (sout3 !== 3'(1 << gidx[c-LAT]) || iout3 !== 2'(gidx[c-LAT]) || dout3 !== din3[gidx[c-LAT]*W +: W])
          begin errors++; $display("FAIL wrap3_out c%0d: sel=%b idx=%0d exp idx %0d", c, sout3, iout3, gidx[c-LAT]); end
      end
      tick();
    end
    vin3 = 3'b0;
  endtask

  task automatic test_single();
    for (int c = 0; c < 8; c++) begin
      vin1 = 1'($urandom_range(0, 1));
      rdy1 = 1'($urandom_range(0, 1));
      din1 = $urandom();
      #1;
      checks++;
      if (rin1 !== rdy1 || vout1 !== vin1 || sout1 !== 1'b1 || iout1 !== 1'b0 || dout1 !== din1)
        begin errors++; $display("FAIL single c%0d: rdy_in=%b v=%b sel=%b idx=%b exp %b/%b/1/0", c, rin1, vout1, sout1, iout1, rdy1, vin1); end
      tick();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!vin[i] || hs[i]) begin
          vin[i] = 1'($urandom_range(0, 1));
          din[i*W +: W] = $urandom();
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      #1;
      checks++;
      if (observe() !== expect_out())
        begin errors++; $display("FAIL random_model c%0d: got %h exp %h", c, observe(), expect_out()); end
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; vin = '0; din = '0; rdy = 1'b0; hs = '0;
    vin3 = '0; din3 = '0; rdy3 = 1'b0;
    vin1 = 1'b0; din1 = '0; rdy1 = 1'b0;
    @(negedge clk);
    test_reset();
    test_rotation();
    test_stall_lock();
    test_reset_stall();
    test_wrap3();
    test_single();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
